processor_controller: RTL and testbench
=======================================

// Module: processor_controller
// PURPOSE
//  Moore FSM control unit for the 16-bit processor datapath (PC, instruction register, data RAM,
//  register file, ALU). Decodes IR[15:12] and sequences INIT/FETCH/DECODE/execute for
//  NOOP, LOAD, STORE, ADD, SUB and HALT. Drives all datapath control strobes.
//  Exports State/NextState for the board-level hex display.
//  Clocked by the debounced push-button clock, so one step per press.
// PARAMETERS
//  ALU_PASS         3'd0  ALU select code for pass-A (idle default)
//  ALU_ADD          3'd1  ALU select code for A+B
//  ALU_SUB          3'd2  ALU select code for A-B
//  HALT_ON_ILLEGAL  0     1: undefined opcode enters HALT; 0: undefined opcode executes as NOOP
// PORTS
//  Clk         in   1   processor clock; all state changes on the rising edge
//  ResetN      in   1   asynchronous, active-low reset
//  IR          in   16  instruction register contents: [15:12] op, [11:8] A, [7:4] B, [3:0] C
//  PC_Clr      out  1   clear PC to 0
//  PC_Up       out  1   increment PC
//  IR_Ld       out  1   load IR from instruction memory at current PC
//  D_Addr      out  8   data RAM address
//  D_Wr        out  1   data RAM write enable
//  RF_s        out  1   register-file write mux: 1 = RAM read data, 0 = ALU output
//  RF_W_Addr   out  4   register-file write address
//  RF_W_en     out  1   register-file write enable
//  RF_Ra_Addr  out  4   register-file read port A address
//  RF_Rb_Addr  out  4   register-file read port B address
//  ALU_s0      out  3   ALU function select
//  State       out  4   current state encoding
//  NextState   out  4   combinational next-state encoding
// BEHAVIOUR
//  States (4-bit code): INIT=0 FETCH=1 DECODE=2 NOOP=3 LOAD_A=4 LOAD_B=5 STORE=6 ADD=7 SUB=8 HALT=9.
//  Opcodes: 0 NOOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 HALT, 6-15 undefined (see HALT_ON_ILLEGAL).
//  Transitions:
//   INIT->FETCH; FETCH->DECODE; DECODE->{NOOP,LOAD_A,STORE,ADD,SUB,HALT} by IR[15:12].
//   LOAD_A->LOAD_B; NOOP/LOAD_B/STORE/ADD/SUB->FETCH; HALT->HALT (exit only by reset).
//  Outputs are pure Moore, decoded from State and IR. Unlisted outputs are 0; ALU_s0=ALU_PASS.
//   INIT:   PC_Clr=1.
//   FETCH:  IR_Ld=1, PC_Up=1. IR and PC update on the edge leaving FETCH.
//   DECODE: no strobes. D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4] (pre-address).
//   LOAD_A: D_Addr=IR[7:0]; absorbs the 1-cycle synchronous RAM read latency.
//   LOAD_B: D_Addr=IR[7:0], RF_s=1, RF_W_en=1, RF_W_Addr=IR[11:8].
//   STORE:  D_Addr=IR[7:0], D_Wr=1, RF_Ra_Addr=IR[11:8].
//   ADD:    RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_en=1, ALU_s0=ALU_ADD.
//   SUB:    as ADD with ALU_s0=ALU_SUB.
//   NOOP, HALT: no strobes.
//  Latency in Clk cycles, FETCH to next FETCH:
//   NOOP/STORE/ADD/SUB = 3; LOAD = 4. First FETCH is 1 cycle after reset release.
//  Strobe exclusivity: at most one of D_Wr and RF_W_en is high in any state.
//   PC_Up and IR_Ld are high only in FETCH.
//  Reset: ResetN=0 forces State=INIT immediately, regardless of Clk.
//   All outputs then take INIT values (PC_Clr=1, D_Wr=0, RF_W_en=0).
//   A write in progress is aborted in the same cycle; no partial write strobe survives reset.
//  NextState is valid every cycle. In INIT under reset it reads FETCH.
//  IR changes while in execute states are not expected. Outputs follow IR combinationally;
//   the controller does not latch IR.
// TESTING
//  Reset then release, 3 edges -> State 0,1,2; PC_Clr=1 only in INIT; IR_Ld=PC_Up=1 only in FETCH.
//  IR=16'h1A2F (LOAD R10<-M[2F]) -> DECODE,LOAD_A,LOAD_B,FETCH; in LOAD_B:
//   RF_s=1, RF_W_en=1, RF_W_Addr=A, D_Addr=2F.
//  IR=16'h2345 (STORE M[45]<-R3) -> STORE asserts D_Wr=1, D_Addr=45, RF_Ra_Addr=3, RF_W_en=0.
//  IR=16'h3126 / 16'h4126 -> ADD/SUB: Ra=1, Rb=2, W_Addr=6, RF_W_en=1, ALU_s0=1 / 2.
//  IR=16'h5000 -> HALT (State=9) held for 10 edges with no strobes; ResetN pulse -> INIT.
//   IR=16'hF000 -> NOOP when HALT_ON_ILLEGAL=0, HALT when 1.
//  ResetN dropped mid-STORE, between edges -> D_Wr falls and State=0 without a Clk edge.

Source files
------------

// File: rtl/processor_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : processor_controller_if
// Description : Control bus between the processor controller and the 16-bit
//               datapath. The master modport is the controller; the slave
//               modport is the datapath and the board-level display.
// Revision    : 1.0 - initial release
// ============================================================================
interface processor_controller_if;
    logic [15:0] IR;
    logic        PC_Clr;
    logic        PC_Up;
    logic        IR_Ld;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  State;
    logic [3:0]  NextState;

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, NextState
    );

    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, NextState
    );
endinterface
`default_nettype wire

// File: rtl/processor_controller.sv
`default_nettype none
// ============================================================================
// Module      : processor_controller
// Description : Moore FSM control unit for the 16-bit processor datapath.
//               Sequences INIT/FETCH/DECODE and the execute states for
//               NOOP, LOAD, STORE, ADD, SUB and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module processor_controller #(
    parameter logic [2:0] ALU_PASS        = 3'd0,
    parameter logic [2:0] ALU_ADD         = 3'd1,
    parameter logic [2:0] ALU_SUB         = 3'd2,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  wire logic               Clk,
    input  wire logic               ResetN,
    processor_controller_if.master  ctrl
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] C_OP_NOOP  = 4'd0;
    localparam logic [3:0] C_OP_LOAD  = 4'd1;
    localparam logic [3:0] C_OP_STORE = 4'd2;
    localparam logic [3:0] C_OP_ADD   = 4'd3;
    localparam logic [3:0] C_OP_SUB   = 4'd4;
    localparam logic [3:0] C_OP_HALT  = 4'd5;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_op;

    assign w_op = ctrl.IR[15:12];

    // State register; reset forces INIT immediately so no strobe outlives it.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore output decode from State and IR.
    always_comb begin
        w_next          = r_state;
        ctrl.PC_Clr     = 1'b0;
        ctrl.PC_Up      = 1'b0;
        ctrl.IR_Ld      = 1'b0;
        ctrl.D_Addr     = 8'h00;
        ctrl.D_Wr       = 1'b0;
        ctrl.RF_s       = 1'b0;
        ctrl.RF_W_Addr  = 4'h0;
        ctrl.RF_W_en    = 1'b0;
        ctrl.RF_Ra_Addr = 4'h0;
        ctrl.RF_Rb_Addr = 4'h0;
        ctrl.ALU_s0     = ALU_PASS;

        case (r_state)
            S_INIT: begin
                ctrl.PC_Clr = 1'b1;
                w_next      = S_FETCH;
            end
            S_FETCH: begin
                ctrl.IR_Ld = 1'b1;
                ctrl.PC_Up = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                // Present addresses early so RAM/RF reads are set up for execute.
                ctrl.D_Addr     = ctrl.IR[7:0];
                ctrl.RF_Ra_Addr = ctrl.IR[11:8];
                ctrl.RF_Rb_Addr = ctrl.IR[7:4];
                case (w_op)
                    C_OP_NOOP:  w_next = S_NOOP;
                    C_OP_LOAD:  w_next = S_LOAD_A;
                    C_OP_STORE: w_next = S_STORE;
                    C_OP_ADD:   w_next = S_ADD;
                    C_OP_SUB:   w_next = S_SUB;
                    C_OP_HALT:  w_next = S_HALT;
                    default:    w_next = HALT_ON_ILLEGAL ? S_HALT : S_NOOP;
                endcase
            end
            S_NOOP: begin
                w_next = S_FETCH;
            end
            S_LOAD_A: begin
                // Wait state covering the synchronous RAM read latency.
                ctrl.D_Addr = ctrl.IR[7:0];
                w_next      = S_LOAD_B;
            end
            S_LOAD_B: begin
                ctrl.D_Addr    = ctrl.IR[7:0];
                ctrl.RF_s      = 1'b1;
                ctrl.RF_W_en   = 1'b1;
                ctrl.RF_W_Addr = ctrl.IR[11:8];
                w_next         = S_FETCH;
            end
            S_STORE: begin
                ctrl.D_Addr     = ctrl.IR[7:0];
                ctrl.D_Wr       = 1'b1;
                ctrl.RF_Ra_Addr = ctrl.IR[11:8];
                w_next          = S_FETCH;
            end
            S_ADD: begin
                ctrl.RF_Ra_Addr = ctrl.IR[11:8];
                ctrl.RF_Rb_Addr = ctrl.IR[7:4];
                ctrl.RF_W_Addr  = ctrl.IR[3:0];
                ctrl.RF_W_en    = 1'b1;
                ctrl.ALU_s0     = ALU_ADD;
                w_next          = S_FETCH;
            end
            S_SUB: begin
                ctrl.RF_Ra_Addr = ctrl.IR[11:8];
                ctrl.RF_Rb_Addr = ctrl.IR[7:4];
                ctrl.RF_W_Addr  = ctrl.IR[3:0];
                ctrl.RF_W_en    = 1'b1;
                ctrl.ALU_s0     = ALU_SUB;
                w_next          = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    assign ctrl.State     = r_state;
    assign ctrl.NextState = w_next;

endmodule
`default_nettype wire

// File: tb/tb_processor_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_controller
// Description : Directed self-checking bench for processor_controller. A
//               second instance built with HALT_ON_ILLEGAL=1 shares the same
//               clock, reset and IR to cover the illegal-opcode option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_controller;

    logic Clk    = 1'b0;
    logic ResetN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    processor_controller_if bus ();
    processor_controller_if bus_h ();

    assign bus_h.IR = bus.IR;

    processor_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .ctrl   (bus)
    );

    processor_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .Clk    (Clk),
        .ResetN (ResetN),
        .ctrl   (bus_h)
    );

    always #5 Clk = ~Clk;

    // {PC_Clr, PC_Up, IR_Ld, D_Wr, RF_W_en, RF_s}
    function automatic logic [5:0] strobes();
        return {bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_W_en, bus.RF_s};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bus.IR = 16'h1A2F;

        // Reset held: INIT, NextState reads FETCH.
        repeat (2) step();
        check("rst_state", 16'(bus.State), 16'd0);
        check("rst_next", 16'(bus.NextState), 16'd1);
        check("rst_strobes", 16'(strobes()), 16'b100000);

        // Release between edges; first edge goes to FETCH.
        @(negedge Clk);
        ResetN = 1'b1;
        step();
        check("fetch_state", 16'(bus.State), 16'd1);
        check("fetch_strobes", 16'(strobes()), 16'b011000);

        // LOAD R10 <- M[2F]
        step();
        check("dec_state", 16'(bus.State), 16'd2);
        check("dec_strobes", 16'(strobes()), 16'b000000);
        check("dec_daddr", 16'(bus.D_Addr), 16'h2F);
        check("dec_ra", 16'(bus.RF_Ra_Addr), 16'hA);
        check("dec_rb", 16'(bus.RF_Rb_Addr), 16'h2);
        check("dec_next_load", 16'(bus.NextState), 16'd4);
        step();
        check("loada_state", 16'(bus.State), 16'd4);
        check("loada_daddr", 16'(bus.D_Addr), 16'h2F);
        check("loada_strobes", 16'(strobes()), 16'b000000);
        step();
        check("loadb_state", 16'(bus.State), 16'd5);
        check("loadb_strobes", 16'(strobes()), 16'b000011);
        check("loadb_waddr", 16'(bus.RF_W_Addr), 16'hA);
        check("loadb_daddr", 16'(bus.D_Addr), 16'h2F);
        step();
        check("load_back_fetch", 16'(bus.State), 16'd1);

        // STORE M[45] <- R3
        bus.IR = 16'h2345;
        step();
        step();
        check("store_state", 16'(bus.State), 16'd6);
        check("store_strobes", 16'(strobes()), 16'b000100);
        check("store_daddr", 16'(bus.D_Addr), 16'h45);
        check("store_ra", 16'(bus.RF_Ra_Addr), 16'h3);
        step();
        check("store_back_fetch", 16'(bus.State), 16'd1);

        // ADD R6 <- R1 + R2
        bus.IR = 16'h3126;
        step();
        step();
        check("add_state", 16'(bus.State), 16'd7);
        check("add_regs", {4'h0, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_Addr}, 16'h0126);
        check("add_strobes", 16'(strobes()), 16'b000010);
        check("add_alu", 16'(bus.ALU_s0), 16'd1);
        step();
        check("add_back_fetch", 16'(bus.State), 16'd1);

        // SUB R6 <- R1 - R2
        bus.IR = 16'h4126;
        step();
        step();
        check("sub_state", 16'(bus.State), 16'd8);
        check("sub_regs", {4'h0, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_Addr}, 16'h0126);
        check("sub_strobes", 16'(strobes()), 16'b000010);
        check("sub_alu", 16'(bus.ALU_s0), 16'd2);
        step();
        check("sub_back_fetch", 16'(bus.State), 16'd1);

        // Illegal opcode: NOOP in the default build, HALT in the other.
        bus.IR = 16'hF000;
        step();
        check("ill_next", 16'(bus.NextState), 16'd3);
        check("ill_next_h", 16'(bus_h.NextState), 16'd9);
        step();
        check("ill_state", 16'(bus.State), 16'd3);
        check("ill_state_h", 16'(bus_h.State), 16'd9);
        check("ill_strobes", 16'(strobes()), 16'b000000);
        step();
        check("ill_back_fetch", 16'(bus.State), 16'd1);

        // Reset dropped mid-STORE, between edges.
        bus.IR = 16'h2345;
        step();
        step();
        check("pre_abort_state", 16'(bus.State), 16'd6);
        check("pre_abort_dwr", 16'(bus.D_Wr), 16'd1);
        #2;
        ResetN = 1'b0;
        #1;
        check("abort_state", 16'(bus.State), 16'd0);
        check("abort_strobes", 16'(strobes()), 16'b100000);
        check("abort_next", 16'(bus.NextState), 16'd1);
        check("abort_state_h", 16'(bus_h.State), 16'd0);

        // HALT holds for 10 edges with no strobes.
        @(negedge Clk);
        ResetN = 1'b1;
        bus.IR = 16'h5000;
        step();
        step();
        step();
        check("halt_state", 16'(bus.State), 16'd9);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold_state", 16'(bus.State), 16'd9);
            check("halt_hold_strobes", {10'h0, strobes()}, 16'h0000);
        end
        check("halt_alu", 16'(bus.ALU_s0), 16'd0);

        // Reset pulse between edges leaves HALT.
        #2;
        ResetN = 1'b0;
        #1;
        check("halt_reset_state", 16'(bus.State), 16'd0);
        ResetN = 1'b1;
        step();
        check("halt_reset_fetch", 16'(bus.State), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
